// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT constants, bit-reversal helper and reducer FSM states
package ntt_pkg;

    localparam int PRIME         = 65537;
    localparam int DEFAULT_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RED1  = 2'd1,
        RED2  = 2'd2,
        DRAIN = 2'd3
    } red_state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage

// File: rtl/mod_reduce_lane.sv
// rtl/mod_reduce_lane.sv - one lane of the two-stage signed-to-canonical modular reduction
module mod_reduce_lane #(
    parameter int WIDTH = 18,
    parameter int PRIME = 65537,
    parameter int OUT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_en1,
    input  logic             i_en2,
    output logic [OUT_W-1:0] o_y
);

    // Wide enough for sign-extended input and for 2*PRIME, whichever is larger.
    localparam int ACC_W = (WIDTH + 2 > $clog2(PRIME) + 3) ? WIDTH + 2 : $clog2(PRIME) + 3;

    logic [ACC_W-1:0] w_x_ext;
    logic [ACC_W-1:0] w_s1;
    logic [ACC_W-1:0] w_s2;
    logic [ACC_W-1:0] r_y1;
    logic [OUT_W-1:0] r_y2;

    assign w_x_ext = {{(ACC_W - WIDTH){i_x[WIDTH-1]}}, i_x};
    assign w_s1    = i_x[WIDTH-1] ? (w_x_ext + ACC_W'(2 * PRIME)) : w_x_ext;
    assign w_s2    = (r_y1 >= ACC_W'(PRIME)) ? (r_y1 - ACC_W'(PRIME)) : r_y1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y1 <= '0;
            r_y2 <= '0;
        end else begin
            if (i_en1) r_y1 <= w_s1;
            if (i_en2) r_y2 <= OUT_W'(w_s2);
        end
    end

    assign o_y = r_y2;

endmodule

// File: rtl/radix8_output_reducer.sv
// rtl/radix8_output_reducer.sv - reduces an 8-lane butterfly frame mod PRIME and streams it out
module radix8_output_reducer
    import ntt_pkg::*;
#(
    parameter int WIDTH      = ntt_pkg::DEFAULT_WIDTH,
    parameter int PRIME      = ntt_pkg::PRIME,
    parameter int OUT_W      = 17,
    parameter bit BITREV_OUT = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_lane_1,
    input  logic signed [WIDTH-1:0] in_lane_2,
    input  logic signed [WIDTH-1:0] in_lane_3,
    input  logic signed [WIDTH-1:0] in_lane_4,
    input  logic signed [WIDTH-1:0] in_lane_5,
    input  logic signed [WIDTH-1:0] in_lane_6,
    input  logic signed [WIDTH-1:0] in_lane_7,
    input  logic signed [WIDTH-1:0] in_lane_8,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [2:0]              out_index,
    output logic                    out_last
);

    // One conditional add plus one conditional subtract only covers inputs within +-2*PRIME.
    if ((64'd1 << (WIDTH - 1)) > (64'd2 * 64'(PRIME))) begin : g_bad_width
        $error("radix8_output_reducer: 2^(WIDTH-1) must not exceed 2*PRIME");
    end
    if ((64'd1 << OUT_W) < 64'(PRIME)) begin : g_bad_out_w
        $error("radix8_output_reducer: OUT_W too narrow for PRIME");
    end

    red_state_t       r_state;
    red_state_t       w_next;
    logic [2:0]       r_k;
    logic [2:0]       w_sel;
    logic [WIDTH-1:0] w_lane_in [8];
    logic [WIDTH-1:0] r_lane    [8];
    logic [OUT_W-1:0] w_buf     [8];
    logic             w_accept;
    logic             w_beat;

    assign w_lane_in[0] = in_lane_1;
    assign w_lane_in[1] = in_lane_2;
    assign w_lane_in[2] = in_lane_3;
    assign w_lane_in[3] = in_lane_4;
    assign w_lane_in[4] = in_lane_5;
    assign w_lane_in[5] = in_lane_6;
    assign w_lane_in[6] = in_lane_7;
    assign w_lane_in[7] = in_lane_8;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_beat   = (r_state == DRAIN) && out_ready;
    assign w_sel    = BITREV_OUT ? bitrev3(r_k) : r_k;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        mod_reduce_lane #(
            .WIDTH (WIDTH),
            .PRIME (PRIME),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .i_x   (r_lane[g]),
            .i_en1 (r_state == RED1),
            .i_en2 (r_state == RED2),
            .o_y   (w_buf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= 3'd0;
            for (int i = 0; i < 8; i++) r_lane[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                for (int i = 0; i < 8; i++) r_lane[i] <= w_lane_in[i];
            end
            // The counter wraps 7->0 on the final beat, so IDLE always starts with k=0.
            if (r_state == RED2)  r_k <= 3'd0;
            else if (w_beat)      r_k <= r_k + 3'd1;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_index = 3'd0;
        out_last  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RED1;
            end
            RED1:  w_next = RED2;
            RED2:  w_next = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = w_buf[w_sel];
                out_index = w_sel;
                out_last  = (r_k == 3'd7);
                if (out_ready && r_k == 3'd7) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_radix8_output_reducer.sv
// tb/tb_radix8_output_reducer.sv - directed self-checking bench for radix8_output_reducer
module tb_radix8_output_reducer;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               out_ready;
    logic signed [17:0] lane [8];

    logic               in_ready_a, out_valid_a, out_last_a;
    logic [16:0]        out_data_a;
    logic [2:0]         out_index_a;
    logic               in_ready_b, out_valid_b, out_last_b;
    logic [16:0]        out_data_b;
    logic [2:0]         out_index_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    radix8_output_reducer #(.WIDTH(18), .PRIME(65537), .OUT_W(17), .BITREV_OUT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_lane_1(lane[0]), .in_lane_2(lane[1]), .in_lane_3(lane[2]), .in_lane_4(lane[3]),
        .in_lane_5(lane[4]), .in_lane_6(lane[5]), .in_lane_7(lane[6]), .in_lane_8(lane[7]),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_index(out_index_a), .out_last(out_last_a)
    );

    radix8_output_reducer #(.WIDTH(18), .PRIME(65537), .OUT_W(17), .BITREV_OUT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_lane_1(lane[0]), .in_lane_2(lane[1]), .in_lane_3(lane[2]), .in_lane_4(lane[3]),
        .in_lane_5(lane[4]), .in_lane_6(lane[5]), .in_lane_7(lane[6]), .in_lane_8(lane[7]),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_index(out_index_b), .out_last(out_last_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int v [8]);
        for (int i = 0; i < 8; i++) lane[i] = 18'(v[i]);
    endtask

    // Presents one frame for a single edge; returns sampled just after the accept edge.
    task automatic send_frame(input int v [8]);
        set_lanes(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) lane[i] = '0;
        tick(); tick();
        n_cmp++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_data_a !== 17'd0 ||
            out_index_a !== 3'd0 || out_last_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: rdy=%b vld=%b data=%0d idx=%0d last=%b, need 1 0 0 0 0",
                     in_ready_a, out_valid_a, out_data_a, out_index_a, out_last_a);
        end
        n_cmp++;
        if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || out_data_b !== 17'd0) begin
            n_err++;
            $display("FAIL reset_b: rdy=%b vld=%b data=%0d, need 1 0 0", in_ready_b, out_valid_b, out_data_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_corners();
        int v   [8] = '{-131072, -1, 0, 65536, 65537, 131071, -65537, 1};
        int exp [8] = '{2, 65536, 0, 65536, 0, 65534, 0, 1};
        bit [2:0] vld_seq = 3'b000;
        out_ready = 1'b1;
        send_frame(v);
        vld_seq[0] = out_valid_a; tick();
        vld_seq[1] = out_valid_a; tick();
        vld_seq[2] = out_valid_a;
        n_cmp++;
        if (vld_seq !== 3'b100) begin
            n_err++;
            $display("FAIL corner_latency: out_valid after accept (T+2..T+0)=%b, need 100", vld_seq);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_valid_a !== 1'b1 || out_data_a !== 17'(exp[k]) || out_index_a !== 3'(k) ||
                out_last_a !== (k == 7)) begin
                n_err++;
                $display("FAIL corner_beat%0d: vld=%b data=%0d idx=%0d last=%b, need 1 %0d %0d %b",
                         k, out_valid_a, out_data_a, out_index_a, out_last_a, exp[k], k, (k == 7));
            end
            tick();
        end
        n_cmp++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL corner_idle: rdy=%b vld=%b, need 1 0", in_ready_a, out_valid_a);
        end
    endtask

    task automatic test_bitrev();
        int v    [8] = '{10, 11, 12, 13, 14, 15, 16, 17};
        int edat [8] = '{10, 14, 12, 16, 11, 15, 13, 17};
        int eidx [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        out_ready = 1'b1;
        send_frame(v);
        tick(); tick();
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_valid_b !== 1'b1 || out_data_b !== 17'(edat[k]) || out_index_b !== 3'(eidx[k]) ||
                out_last_b !== (k == 7)) begin
                n_err++;
                $display("FAIL bitrev_beat%0d: vld=%b data=%0d idx=%0d last=%b, need 1 %0d %0d %b",
                         k, out_valid_b, out_data_b, out_index_b, out_last_b, edat[k], eidx[k], (k == 7));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int v   [8] = '{100, -5, 70000, -70000, 3, 65537, -2, 131071};
        int exp [8] = '{100, 65532, 4463, 61074, 3, 0, 65535, 65534};
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n_hs = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [16:0] held_d = '0;
        logic [2:0]  held_i = '0;
        out_ready = 1'b0;
        send_frame(v);
        while (n_hs < 8 && cyc < 60) begin
            out_ready = pat[cyc % 4];
            if (out_valid_a) begin
                if (stalled) begin
                    n_cmp++;
                    if (out_data_a !== held_d || out_index_a !== held_i) begin
                        n_err++;
                        $display("FAIL bp_stable: data=%0d idx=%0d, need %0d %0d",
                                 out_data_a, out_index_a, held_d, held_i);
                    end
                end
                if (out_ready) begin
                    n_cmp++;
                    if (out_data_a !== 17'(exp[n_hs]) || out_index_a !== 3'(n_hs)) begin
                        n_err++;
                        $display("FAIL bp_beat%0d: data=%0d idx=%0d, need %0d %0d",
                                 n_hs, out_data_a, out_index_a, exp[n_hs], n_hs);
                    end
                    n_hs++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = out_data_a;
                    held_i  = out_index_a;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (n_hs != 8 || in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL bp_count: handshakes=%0d rdy=%b vld=%b, need 8 1 0", n_hs, in_ready_a, out_valid_a);
        end
    endtask

    task automatic test_back_to_back();
        int va [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
        int vb [8] = '{-3, 9, 9, 9, 9, 9, 9, 9};
        int n_edges = 0;
        bit last_rdy_bad = 1'b0;
        out_ready = 1'b1;
        set_lanes(va);
        in_valid = 1'b1;
        tick();
        set_lanes(vb);
        do begin
            tick();
            n_edges++;
            if (out_valid_a && out_last_a && in_ready_a) last_rdy_bad = 1'b1;
        end while (!in_ready_a && n_edges < 30);
        n_cmp++;
        if (n_edges + 1 != 11) begin
            n_err++;
            $display("FAIL b2b_period: frame period=%0d cycles, need 11", n_edges + 1);
        end
        n_cmp++;
        if (last_rdy_bad) begin
            n_err++;
            $display("FAIL b2b_last_ready: in_ready=1 during final beat, need 0");
        end
        tick();
        in_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if (out_valid_a !== 1'b1 || out_data_a !== 17'd65534 || out_index_a !== 3'd0) begin
            n_err++;
            $display("FAIL b2b_frame2: vld=%b data=%0d idx=%0d, need 1 65534 0",
                     out_valid_a, out_data_a, out_index_a);
        end
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_reset_mid_drain();
        int va [8] = '{5, 5, 5, 5, 5, 5, 5, 5};
        int vc [8] = '{-1, -2, -3, -4, -5, -6, -7, -8};
        int exp [8] = '{65536, 65535, 65534, 65533, 65532, 65531, 65530, 65529};
        out_ready = 1'b1;
        send_frame(va);
        tick(); tick();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== 17'd0) begin
            n_err++;
            $display("FAIL mid_reset: vld=%b rdy=%b data=%0d, need 0 1 0", out_valid_a, in_ready_a, out_data_a);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (out_valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_no_beats: vld=%b, need 0", out_valid_a);
        end
        send_frame(vc);
        tick(); tick();
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_valid_a !== 1'b1 || out_data_a !== 17'(exp[k]) || out_index_a !== 3'(k)) begin
                n_err++;
                $display("FAIL post_reset_beat%0d: vld=%b data=%0d idx=%0d, need 1 %0d %0d",
                         k, out_valid_a, out_data_a, out_index_a, exp[k], k);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_bitrev();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, need completion");
        $fatal(1);
    end

endmodule
